// File: rtl/qpl_evt_pkg.sv
// qpl_evt_pkg
//   Shared constants for the QPL event stream transmitter.
//   - Payload field offsets for o_data / o_user.
//   - Channel-index width helper.
//   - Width of the saturating dropped-event counter.
package qpl_evt_pkg;

    // o_data fields. The avail field sits directly above the address field,
    // so AVAIL_LSB is the gap between the end of addr and the start of avail.
    localparam int ADDR_LSB     = 0;
    localparam int AVAIL_LSB    = 0;

    // o_user fields: aux flag at bit 0, channel index above it, full flag above that.
    localparam int USR_AUX      = 0;
    localparam int USR_CHAN_LSB = 1;

    localparam int DROP_CNT_W   = 16;

    function automatic int chan_w(input int chans);
        return (chans <= 1) ? 1 : $clog2(chans);
    endfunction

endpackage

// File: rtl/qpl_evt_fifo.sv
// qpl_evt_fifo
//   Synchronous FIFO with registered storage. Push and pop may occur in the
//   same cycle, including when full (the popped entry makes room for the push).
//   The head entry is presented combinationally on dout.
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset (pointers and count only)
//   push   in   write din this cycle (ignored if full and no pop)
//   din    in   entry to write
//   pop    in   remove head entry this cycle (ignored if empty)
//   dout   out  head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  occupancy, 0..DEPTH
module qpl_evt_fifo
    import qpl_evt_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/qpl_evt_strm_tx.sv
// qpl_evt_strm_tx
//   Serialises QPL allocator base/aux address write events onto a vld/rdy
//   stream. Each of the 2*CHANS sources (s = 2*chan + aux) has one pending
//   slot; a round-robin arbiter moves at most one slot per cycle into the event
//   FIFO, whose head drives the stream. The allocator is never stalled: a write
//   event hitting an occupied, non-granted slot is dropped and counted.
//   Build option: define QPL_EVT_TSTAMP_EN to stamp each event with a
//   free-running TS_W-bit cycle counter in o_data[DATA_W-1 -: TS_W].
// Ports
//   i_clk            in   clock
//   i_rst            in   synchronous active-high reset
//   i_blk_full       in   allocator full flag
//   i_blk_avail      in   free block count (BLOCK_W+1 bits)
//   i_blk_base_we    in   per-channel base address write event
//   i_blk_aux_we     in   per-channel aux address write event
//   i_blk_base_addr  in   per-channel base address, channel c at [c*ADDR_W +: ADDR_W]
//   i_blk_aux_addr   in   per-channel aux address, same packing
//   i_rdy            in   stream ready
//   o_vld            out  stream valid
//   o_data           out  {ts, avail, addr} payload, unused bits 0
//   o_user           out  {full, chan, aux} tag, unused bits 0
//   o_last           out  last queued beat with nothing arriving behind it
//   o_ovf            out  sticky drop flag
//   o_drop_cnt       out  saturating dropped-event count
module qpl_evt_strm_tx
    import qpl_evt_pkg::*;
#(
    parameter int CHANS      = 2,
    parameter int BLOCK_W    = 8,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int USER_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_blk_full,
    input  logic [BLOCK_W:0]        i_blk_avail,
    input  logic [CHANS-1:0]        i_blk_base_we,
    input  logic [CHANS-1:0]        i_blk_aux_we,
    input  logic [CHANS*ADDR_W-1:0] i_blk_base_addr,
    input  logic [CHANS*ADDR_W-1:0] i_blk_aux_addr,
    input  logic                    i_rdy,
    output logic                    o_vld,
    output logic [DATA_W-1:0]       o_data,
    output logic [USER_W-1:0]       o_user,
    output logic                    o_last,
    output logic                    o_ovf,
    output logic [DROP_CNT_W-1:0]   o_drop_cnt
);

    localparam int S      = 2 * CHANS;
    localparam int SRC_W  = $clog2(S);
    localparam int CHAN_W = chan_w(CHANS);
    localparam int AV_LSB = ADDR_LSB + ADDR_W + AVAIL_LSB;
    localparam int ENT_W  = DATA_W + USER_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BLOCK_W:0]  avail;
        logic              full;
`ifdef QPL_EVT_TSTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } evt_t;

    evt_t              slot_q [S];
    logic [S-1:0]      occ_q;
    logic [S-1:0]      occ_d;
    logic [S-1:0]      cap;
    logic [S-1:0]      drop_vec;
    logic [SRC_W-1:0]  ptr_q;
    logic [S-1:0]      we_src;
    logic [ADDR_W-1:0] addr_src [S];

    logic              gnt_found;
    logic [SRC_W-1:0]  gnt_idx;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [USER_W-1:0] push_user;

    logic [ENT_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W:0]   drop_sum;

    // (p + i) mod S without a divider; i is always < S here.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] p, input int i);
        int t;
        t = int'(p) + i;
        if (t >= S) t = t - S;
        return t[SRC_W-1:0];
    endfunction

`ifdef QPL_EVT_TSTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end
`endif

    // Flatten the per-channel inputs into the source index space s = 2*c + aux.
    always_comb begin
        we_src = '0;
        for (int c = 0; c < CHANS; c++) begin
            we_src[2*c]     = i_blk_base_we[c];
            we_src[2*c+1]   = i_blk_aux_we[c];
            addr_src[2*c]   = i_blk_base_addr[c*ADDR_W +: ADDR_W];
            addr_src[2*c+1] = i_blk_aux_addr[c*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < S; i++) begin
            if (!gnt_found && occ_q[rr_idx(ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(ptr_q, i);
            end
        end
    end

    assign o_vld = !fifo_empty;
    assign pop   = o_vld && i_rdy;
    assign push  = gnt_found && (!fifo_full || pop);

    // A slot granted this cycle is free again at the edge, so a write event
    // arriving in the same cycle refills it instead of being dropped.
    always_comb begin
        occ_d    = occ_q;
        cap      = '0;
        drop_vec = '0;
        for (int s = 0; s < S; s++) begin
            if (push && (gnt_idx == SRC_W'(s))) begin
                occ_d[s] = we_src[s];
                cap[s]   = we_src[s];
            end else if (occ_q[s]) begin
                drop_vec[s] = we_src[s];
            end else if (we_src[s]) begin
                occ_d[s] = 1'b1;
                cap[s]   = 1'b1;
            end
        end
    end

    always_comb begin
        push_data = '0;
        push_user = '0;
        push_data[ADDR_LSB +: ADDR_W]   = slot_q[gnt_idx].addr;
        push_data[AV_LSB +: BLOCK_W+1]  = slot_q[gnt_idx].avail;
`ifdef QPL_EVT_TSTAMP_EN
        push_data[DATA_W-1 -: TS_W]     = slot_q[gnt_idx].ts;
`else
        push_data[DATA_W-1 -: TS_W]     = '0;
`endif
        push_user[USR_AUX]                 = gnt_idx[0];
        push_user[USR_CHAN_LSB +: CHAN_W]  = CHAN_W'(gnt_idx >> 1);
        push_user[USR_CHAN_LSB + CHAN_W]   = slot_q[gnt_idx].full;
    end

    assign drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'($countones(drop_vec));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q      <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) ptr_q <= rr_idx(gnt_idx, 1);
            if (|drop_vec) ovf_q <= 1'b1;
            drop_cnt_q <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < S; s++) begin
            if (!i_rst && cap[s]) begin
                slot_q[s].addr  <= addr_src[s];
                slot_q[s].avail <= i_blk_avail;
                slot_q[s].full  <= i_blk_full;
`ifdef QPL_EVT_TSTAMP_EN
                slot_q[s].ts    <= ts_q;
`endif
            end
        end
    end

    qpl_evt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .din   ({push_data, push_user}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Storage behind an empty FIFO is stale, so the payload is forced to 0.
    assign o_data     = o_vld ? fifo_dout[ENT_W-1:USER_W] : '0;
    assign o_user     = o_vld ? fifo_dout[USER_W-1:0] : '0;
    assign o_last     = o_vld && (fifo_count == CNT_W'(1)) && !push;
    assign o_ovf      = ovf_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
